stage_sequencer: RTL
====================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- N, 64, width of the current_altitude bus.
- BURN1, 1000, stage-1 burn length in cycles (>=1).
- BURN2, 1000, stage-2 burn length in cycles (>=1).
- BURN3, 1000, stage-3 first (orbit-insertion) burn length in cycles (>=1).
- BURN4, 1000, stage-3 second burn length in cycles (>=1).
- SEP_CYCLES, 10, separation gap in cycles (>=1).
- COAST_CYCLES, 100, coast between burn 3 and burn 4 in cycles (>=1).
- LEO_ALT, 188, burn-3 altitude cutoff, same scaling as current_altitude.

REQ-002 SHALL have ports, one per line:
- clk  in  1  clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- launch  in  1  start request, sampled in IDLE only.
- abort  in  1  level abort request.
- current_altitude  in  N  unsigned altitude.
- stage_state  out  4  0=pad, 1..4=active burn index.
- ignition_end  out  1  one-cycle burn-complete pulse.
- thrust_on  out  1  engine firing.
- separating  out  1  separation phase active.
- mission_done  out  1  all burns complete.
- aborted  out  1  abort latched.
- burn_count  out  32  cycles elapsed in the current burn.

Function
REQ-003 SHALL implement a single-clock FSM with states IDLE, BURN, SEP, COAST, DONE, ABORT; all outputs SHALL be registered.
REQ-004 In IDLE with launch=1: next cycle is BURN, stage_state=1, burn_count=0, thrust_on=1.
REQ-005 In IDLE with launch=0: the FSM stays in IDLE.
REQ-006 In BURN, burn_count SHALL increment by 1 each cycle; the terminal condition is burn_count==BURNn-1, where n=stage_state.
REQ-007 For stage_state=3 only, the terminal condition SHALL also fire when current_altitude>=LEO_ALT (unsigned compare).
- Count and altitude terminal in the same cycle SHALL produce one single termination.
REQ-008 On terminal, the next cycle SHALL have: ignition_end=1 for exactly one cycle, thrust_on=0, stage_state unchanged, burn_count held.
REQ-009 After terminal, the next state SHALL be:
- SEP after stage 1 or 2.
- COAST after stage 3.
- DONE after stage 4.
REQ-010 SEP SHALL last exactly SEP_CYCLES cycles with separating=1.
- The next cycle SHALL then be BURN with stage_state incremented, burn_count=0, thrust_on=1.
REQ-011 COAST SHALL last exactly COAST_CYCLES cycles with separating=0 and thrust_on=0.
- The next cycle SHALL then be BURN with stage_state=4, burn_count=0.
REQ-012 In DONE: mission_done=1, stage_state=4, thrust_on=0; the FSM SHALL remain in DONE until reset.
REQ-013 The launch input SHALL be ignored in every state except IDLE.
REQ-014 abort=1 in any state except DONE SHALL move the FSM to ABORT on the next edge with: aborted=1, thrust_on=0, separating=0, ignition_end=0, stage_state frozen.
- ABORT SHALL be held until reset.
REQ-015 When abort and a burn terminal occur in the same cycle, abort SHALL win and no ignition_end pulse SHALL be issued.
REQ-016 burn_count SHALL never wrap, because the terminal condition bounds it below BURNn.
REQ-017 ignition_end SHALL pulse at most once per stage_state value.

Reset
REQ-018 reset=1 SHALL asynchronously force IDLE with every output at 0.
- Outputs: stage_state=0, ignition_end=0, thrust_on=0, separating=0, mission_done=0, aborted=0, burn_count=0.
REQ-019 Reset asserted mid-burn or in ABORT SHALL return the FSM to IDLE.
- After release, the next launch SHALL start from stage 1.

Verification
Bench parameters for all scenarios: BURN1=5, BURN2=4, BURN3=6, BURN4=3, SEP_CYCLES=2, COAST_CYCLES=3, LEO_ALT=100.
REQ-020 Nominal run: one-cycle launch pulse, altitude=0.
- stage_state=1 for 5 cycles, then an ignition_end pulse with stage_state=1.
- separating for 2 cycles, then stage_state=2 for 4 cycles.
- Pulses SHALL be seen at stage_state 1, 2, 3 and 4.
- Coast of 3 cycles before stage 4; mission_done=1 after the stage-4 pulse.
REQ-021 Altitude cutoff: altitude set to 100 on the 2nd cycle of burn 3.
- ignition_end SHALL occur on the next cycle with burn_count=1, then COAST begins.
REQ-022 Abort mid-burn: abort asserted on cycle 3 of stage 2.
- Next cycle: aborted=1, thrust_on=0, stage_state=2, no ignition_end.
- Outputs hold for 20 cycles.
REQ-023 Abort and terminal coincide: abort asserted on the cycle burn_count==4 in stage 1.
- No ignition_end pulse; aborted=1.
REQ-024 Reset and relaunch:
- reset pulse during SEP: all outputs 0 immediately (asynchronous).
- launch during DONE: ignored.
- after reset, a new launch yields stage_state=1, burn_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: four-burn launch sequencer with separation, coast,
// altitude cutoff on burn 3 and a latched abort.
module stage_sequencer #(
  parameter int N            = 64,
  parameter int BURN1        = 1000,
  parameter int BURN2        = 1000,
  parameter int BURN3        = 1000,
  parameter int BURN4        = 1000,
  parameter int SEP_CYCLES   = 10,
  parameter int COAST_CYCLES = 100,
  parameter int LEO_ALT      = 188
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         launch,
  input  logic         abort,
  input  logic [N-1:0] current_altitude,
  output logic [3:0]   stage_state,
  output logic         ignition_end,
  output logic         thrust_on,
  output logic         separating,
  output logic         mission_done,
  output logic         aborted,
  output logic [31:0]  burn_count
);

  typedef enum logic [2:0] {
    IDLE,
    BURN,
    IGN_END,
    SEP,
    COAST,
    DONE,
    ABORT
  } state_t;

  localparam logic [N-1:0] LEO = N'(LEO_ALT);
  localparam logic [31:0] SEP_LAST = 32'(SEP_CYCLES - 1);
  localparam logic [31:0] COAST_LAST = 32'(COAST_CYCLES - 1);

  state_t      state;
  logic [31:0] tmr;
  logic [31:0] burn_lim;
  logic        at_leo;
  logic        term;

  always_comb begin
    burn_lim = 32'(BURN1 - 1);
    case (stage_state)
      4'd2: burn_lim = 32'(BURN2 - 1);
      4'd3: burn_lim = 32'(BURN3 - 1);
      4'd4: burn_lim = 32'(BURN4 - 1);
      default: burn_lim = 32'(BURN1 - 1);
    endcase
  end

  assign at_leo = (stage_state == 4'd3) && (current_altitude >= LEO);
  assign term   = (burn_count == burn_lim) || at_leo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmr          <= '0;
      stage_state  <= '0;
      ignition_end <= 1'b0;
      thrust_on    <= 1'b0;
      separating   <= 1'b0;
      mission_done <= 1'b0;
      aborted      <= 1'b0;
      burn_count   <= '0;
    end else if (abort && state != DONE && state != ABORT) begin
      // abort wins over a same-cycle terminal: no pulse is issued
      state        <= ABORT;
      aborted      <= 1'b1;
      thrust_on    <= 1'b0;
      separating   <= 1'b0;
      ignition_end <= 1'b0;
    end else begin
      ignition_end <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= BURN;
            stage_state <= 4'd1;
            burn_count  <= '0;
            thrust_on   <= 1'b1;
          end
        end
        BURN: begin
          if (term) begin
            state        <= IGN_END;
            ignition_end <= 1'b1;
            thrust_on    <= 1'b0;
          end else begin
            burn_count <= burn_count + 32'd1;
          end
        end
        IGN_END: begin
          tmr <= '0;
          if (stage_state == 4'd4) begin
            state        <= DONE;
            mission_done <= 1'b1;
          end else if (stage_state == 4'd3) begin
            state <= COAST;
          end else begin
            state      <= SEP;
            separating <= 1'b1;
          end
        end
        SEP: begin
          if (tmr == SEP_LAST) begin
            state       <= BURN;
            separating  <= 1'b0;
            stage_state <= stage_state + 4'd1;
            burn_count  <= '0;
            thrust_on   <= 1'b1;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        COAST: begin
          if (tmr == COAST_LAST) begin
            state       <= BURN;
            stage_state <= 4'd4;
            burn_count  <= '0;
            thrust_on   <= 1'b1;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
